serial_subtractor: RTL and testbench

// - Bit-serial full subtractor: computes DIFF = A - B - BIN over WIDTH cycles, LSB first,
//   one full-subtractor slice plus a borrow flip-flop.
// - Counterpart to the combinational full adder: the same slice structure, run in the

---
 rtl/serial_subtractor.sv | 136 +++++++++++++
 tb/tb_serial_subtractor.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: DIFF = A - B - BIN over WIDTH cycles, LSB first.
// One full-subtractor slice plus a borrow flop; chainable through bin/bout.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             accept_c;
  logic             last_c;
  logic             ai_c;
  logic             bi_c;
  logic             d_c;
  logic             br_next_c;
  logic [WIDTH-1:0] d_shift_c;

`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  // Full-subtractor slice on the current operand LSBs and the borrow reg
  always_comb begin
    ai_c      = a_sr[0];
    bi_c      = b_sr[0];
    d_c       = ai_c ^ bi_c ^ br;
    br_next_c = (~ai_c & bi_c) | (~(ai_c ^ bi_c) & br);
    d_shift_c = {d_c, d_sr[WIDTH-1:1]};
    last_c    = (cnt == CW'(WIDTH - 1));
    accept_c  = start && (state != S_RUN);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a start in DONE is accepted like in IDLE
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept_c) state_next = S_RUN;
      S_RUN:   if (last_c)   state_next = S_DONE;
      S_DONE:  state_next = accept_c ? S_RUN : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode straight from the state flops
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Operand latch, per-bit shifting, and result update on the final RUN edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      d_sr  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else if (accept_c) begin
      a_sr  <= a;
      b_sr  <= b;
      d_sr  <= '0;
      br    <= bin;
      cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
`endif
    end else if (state == S_RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      d_sr <= d_shift_c;
      br   <= br_next_c;
      cnt  <= cnt + CW'(1);
      if (last_c) begin
        diff <= d_shift_c;
        bout <= br_next_c;
`ifdef SERIAL_SUB_OVF_EN
        // The result MSB is the bit produced on this final step
        ovf  <= (a_msb != b_msb) && (d_c != a_msb);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
// Define SERIAL_SUB_OVF_EN on both files to exercise the ovf output.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands with a one-cycle start pulse; returns just after the sampling edge
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bv_in);
    a     = av;
    b     = bv;
    bin   = bv_in;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Wait (bounded) for done; check latency, busy duration and the result
  task automatic wait_result(input string tag, input int exp_n,
                             input logic [W-1:0] exp_diff, input logic exp_bout,
                             input logic exp_ovf);
    int n = 0;
    int busy_n = 0;
    while (!done && n < 40) begin
      if (busy) busy_n++;
      step();
      n++;
    end
    check({tag, " latency"}, n, exp_n);
    check({tag, " busy cycles"}, busy_n, exp_n);
    check({tag, " diff"}, 32'(diff), 32'(exp_diff));
    check({tag, " bout"}, 32'(bout), 32'(exp_bout));
    check({tag, " busy at done"}, 32'(busy), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check({tag, " ovf"}, 32'(ovf), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) $display("note: unexpected x ovf expectation in %s", tag);
`endif
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset diff", 32'(diff), 32'd0);
    check("reset bout", 32'(bout), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Basic directed vectors
    launch(8'h35, 8'h12, 1'b0);
    check("busy after start", 32'(busy), 32'd1);
    wait_result("35-12", W, 8'h23, 1'b0, 1'b0);
    step();
    check("done one cycle", 32'(done), 32'd0);
    check("diff held", 32'(diff), 32'h23);

    launch(8'h12, 8'h35, 1'b0);
    wait_result("12-35", W, 8'hDD, 1'b1, 1'b0);
    step();
    launch(8'h00, 8'h00, 1'b1);
    wait_result("00-00-1", W, 8'hFF, 1'b1, 1'b0);
    step();
    launch(8'hA0, 8'hA0, 1'b0);
    wait_result("A0-A0", W, 8'h00, 1'b0, 1'b0);
    step();
    launch(8'hFF, 8'h00, 1'b1);
    wait_result("FF-00-1", W, 8'hFE, 1'b0, 1'b0);
    step();
    launch(8'h00, 8'hFF, 1'b0);
    wait_result("00-FF", W, 8'h01, 1'b1, 1'b0);
    step();

    // Start while busy is ignored
    launch(8'h35, 8'h12, 1'b0);
    step();
    step();
    launch(8'hFF, 8'h00, 1'b0);
    wait_result("ignored start", W - 3, 8'h23, 1'b0, 1'b0);
    step();
    check("idle after ignored", 32'(busy), 32'd0);

    // Reset in the middle of a run
    launch(8'h35, 8'h12, 1'b0);
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst diff", 32'(diff), 32'd0);
    check("midrst bout", 32'(bout), 32'd0);
    for (int i = 0; i < 12; i++) begin
      step();
      check("midrst no done", 32'(done), 32'd0);
    end
    rst = 1'b0;
    step();
    check("post rst idle", 32'(busy), 32'd0);
    launch(8'h10, 8'h01, 1'b0);
    wait_result("10-01 after rst", W, 8'h0F, 1'b0, 1'b0);

    // Back-to-back: start sampled in the DONE cycle
    launch(8'h12, 8'h35, 1'b0);
    check("b2b busy no gap", 32'(busy), 32'd1);
    check("b2b done cleared", 32'(done), 32'd0);
    check("b2b diff held", 32'(diff), 32'h0F);
    wait_result("b2b 12-35", W, 8'hDD, 1'b1, 1'b0);
    step();

    // Signed overflow cases (ovf only checked when the feature is built in)
    launch(8'h80, 8'h01, 1'b0);
    wait_result("80-01", W, 8'h7F, 1'b0, 1'b1);
    step();
    launch(8'h7F, 8'h01, 1'b0);
    wait_result("7F-01", W, 8'h7E, 1'b0, 1'b0);
    step();
    launch(8'h7F, 8'hFF, 1'b0);
    wait_result("7F-FF", W, 8'h80, 1'b1, 1'b1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
